// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I main controller: sequences one instruction at a time through
// fetch/decode/execute/memory/writeback on a shared ALU and unified memory port.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         OPCode,
  input  logic [2:0]         funct3,
  input  logic               funct75,
  input  logic [3:0]         ALUFlags,
  input  logic               memReady,
  output logic               memReq,
  output logic               memWrite,
  output logic               adrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               regWrite,
  output logic [1:0]         srcA,
  output logic [1:0]         srcB,
  output logic [1:0]         resultSrc,
  output logic [2:0]         immSource,
  output logic [3:0]         ALUControl,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);
  // state  | meaning
  // RST    | idle cycle after reset, all outputs low
  // FETCH  | read instruction at PC; IR/OldPC and PC+4 load on memReady
  // DECODE | OldPC+imm (branch/jump target) into ALUOut
  // MEMADR | rs1+imm address for load/store
  // MEMRD  | load read, waits on memReady
  // MEMWB  | loaded data to rd
  // MEMWR  | store write, waits on memReady
  // EXECR  | register-register ALU op
  // EXECI  | register-immediate ALU op
  // ALUWB  | ALUOut to rd
  // JAL    | rd <= OldPC+4, PC <= ALUOut
  // JALR   | rs1+imm target into ALUOut, then JAL
  // LUI    | U-imm plus zero (LUI) or OldPC (AUIPC)
  // BRANCH | rs1-rs2 compare, PC <= ALUOut when taken
  // TRAP   | illegal instruction, held until reset
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_JAL, S_JALR, S_LUI, S_BRANCH, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

  state_e state_q, state_d;
  logic   taken;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f75,
                                            input logic is_r);
    case (f3)
      3'b000:  return (f75 && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f75 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ALUFlags = {N,Z,C,V}; C set means no borrow, so !C is unsigned less-than.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = ALUFlags[2];
      3'b001:  taken = !ALUFlags[2];
      3'b100:  taken = ALUFlags[3] ^ ALUFlags[0];
      3'b101:  taken = !(ALUFlags[3] ^ ALUFlags[0]);
      3'b110:  taken = !ALUFlags[1];
      3'b111:  taken = ALUFlags[1];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    memReq     = 1'b0;
    memWrite   = 1'b0;
    adrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    regWrite   = 1'b0;
    srcA       = 2'd0;
    srcB       = 2'd0;
    resultSrc  = 2'd0;
    immSource  = IMM_I;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        memReq = 1'b1;
        srcB   = 2'd2;
        if (memReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        srcA = 2'd1;
        srcB = 2'd1;
        case (OPCode)
          OP_BRANCH:        immSource = IMM_B;
          OP_JAL:           immSource = IMM_J;
          OP_STORE:         immSource = IMM_S;
          OP_LUI, OP_AUIPC: immSource = IMM_U;
          default:          immSource = IMM_I;
        endcase
        case (OPCode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_LUI;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        srcA      = 2'd2;
        srcB      = 2'd1;
        immSource = (OPCode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (OPCode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = 2'd1;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        adrSrc   = 1'b1;
        if (memReady) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        srcA       = 2'd2;
        srcB       = (state_q == S_EXECI) ? 2'd1 : 2'd0;
        ALUControl = alu_decode(funct3, funct75, state_q == S_EXECR);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        srcA      = 2'd1;
        srcB      = 2'd2;
        resultSrc = 2'd2;
        regWrite  = 1'b1;
        PCWrite   = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        srcA    = 2'd2;
        srcB    = 2'd1;
        state_d = S_JAL;
      end
      S_LUI: begin
        immSource = IMM_U;
        srcB      = 2'd1;
        srcA      = (OPCode == OP_LUI) ? 2'd3 : 2'd1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        srcA       = 2'd2;
        ALUControl = ALU_SUB;
        PCWrite    = taken;
        state_d    = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_RST;
    endcase
  end

  assign state = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model expands each
// instruction into its expected per-cycle control outputs; a monitor compares every cycle.
module tb_multicycle_ctrl;
  localparam int STATE_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [6:0]         OPCode;
  logic [2:0]         funct3;
  logic               funct75;
  logic [3:0]         ALUFlags;
  logic               memReady;
  logic               memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, illegal;
  logic [1:0]         srcA, srcB, resultSrc;
  logic [2:0]         immSource;
  logic [3:0]         ALUControl;
  logic [STATE_W-1:0] state;

  multicycle_ctrl #(.STATE_W(STATE_W)) dut (
    .clk(clk), .reset(reset), .OPCode(OPCode), .funct3(funct3), .funct75(funct75),
    .ALUFlags(ALUFlags), .memReady(memReady), .memReq(memReq), .memWrite(memWrite),
    .adrSrc(adrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .regWrite(regWrite),
    .srcA(srcA), .srcB(srcB), .resultSrc(resultSrc), .immSource(immSource),
    .ALUControl(ALUControl), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite;
    logic [1:0] srcA, srcB, resultSrc;
    logic [2:0] immSource;
    logic [3:0] alu;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic        rst, rdy, chk;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [3:0]  flags;
    logic [63:0] tag;
    outs_t       exp;
  } step_t;

  step_t plan_q[$];
  step_t sb_q[$];
  int    passed = 0;
  int    total  = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f75;
  logic [3:0] cur_flags;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f75, input bit is_r);
    case (f3)
      3'b000:  return (is_r && f75) ? 4'd1 : 4'd0;
      3'b001:  return 4'd7;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b100:  return 4'd4;
      3'b101:  return f75 ? 4'd9 : 4'd8;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
    bit n = fl[3], z = fl[2], c = fl[1], v = fl[0];
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OP_BRANCH) return 3'd2;
    if (op == OP_JAL)    return 3'd3;
    if (op == OP_STORE)  return 3'd1;
    if (op == OP_LUI || op == OP_AUIPC) return 3'd4;
    return 3'd0;
  endfunction

  task automatic add(input logic [63:0] tag, input outs_t e, input logic rdy, input logic rst,
                     input logic chk);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.chk = chk;
    s.op = cur_op; s.f3 = cur_f3; s.f75 = cur_f75; s.flags = cur_flags;
    s.tag = tag; s.exp = e;
    plan_q.push_back(s);
  endtask

  task automatic add_rst_state();
    add("RST", '0, rbit(), 1'b0, 1'b1);
  endtask

  task automatic plan_trap();
    outs_t o = '0;
    int    k = int'($urandom_range(1, 3));
    o.illegal = 1'b1;
    for (int i = 0; i < k; i++) add("TRAP", o, rbit(), 1'b0, 1'b1);
    add("TRAP", o, rbit(), 1'b1, 1'b1);
    add_rst_state();
  endtask

  task automatic plan_writeback_alu();
    outs_t o = '0;
    o.regWrite = 1'b1;
    add("ALUWB", o, rbit(), 1'b0, 1'b1);
  endtask

  task automatic plan_jal();
    outs_t o = '0;
    o.srcA = 2'd1; o.srcB = 2'd2; o.resultSrc = 2'd2; o.regWrite = 1'b1; o.PCWrite = 1'b1;
    add("JAL", o, rbit(), 1'b0, 1'b1);
  endtask

  // Expands one instruction into its expected cycle-by-cycle control outputs.
  task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                            input logic [3:0] flags, input int fw, input int mw,
                            input bit rst_mid);
    outs_t o;
    cur_op = op; cur_f3 = f3; cur_f75 = f75; cur_flags = flags;
    o = '0; o.memReq = 1'b1; o.srcB = 2'd2;
    for (int i = 0; i < fw; i++) add("FETCH", o, 1'b0, 1'b0, 1'b1);
    o.IRWrite = 1'b1; o.PCWrite = 1'b1;
    add("FETCH", o, 1'b1, 1'b0, 1'b1);
    o = '0; o.srcA = 2'd1; o.srcB = 2'd1; o.immSource = imm_of(op);
    add("DECODE", o, rbit(), 1'b0, 1'b1);
    case (op)
      OP_LOAD, OP_STORE: begin
        o = '0; o.srcA = 2'd2; o.srcB = 2'd1; o.immSource = (op == OP_STORE) ? 3'd1 : 3'd0;
        add("MEMADR", o, rbit(), 1'b0, 1'b1);
        o = '0; o.memReq = 1'b1; o.adrSrc = 1'b1; o.memWrite = (op == OP_STORE);
        if (rst_mid) begin
          add("MEMWAIT", o, 1'b0, 1'b0, 1'b1);
          add("MEMWAIT", o, 1'b0, 1'b0, 1'b1);
          add("MEMWAIT", o, 1'b0, 1'b1, 1'b1);
          add_rst_state();
        end else begin
          for (int i = 0; i < mw; i++) add("MEMWAIT", o, 1'b0, 1'b0, 1'b1);
          add("MEMDONE", o, 1'b1, 1'b0, 1'b1);
          if (op == OP_LOAD) begin
            o = '0; o.resultSrc = 2'd1; o.regWrite = 1'b1;
            add("MEMWB", o, rbit(), 1'b0, 1'b1);
          end
        end
      end
      OP_R, OP_I: begin
        o = '0; o.srcA = 2'd2; o.srcB = (op == OP_I) ? 2'd1 : 2'd0;
        o.alu = alu_of(f3, f75, op == OP_R);
        add("EXEC", o, rbit(), 1'b0, 1'b1);
        plan_writeback_alu();
      end
      OP_JAL: plan_jal();
      OP_JALR: begin
        o = '0; o.srcA = 2'd2; o.srcB = 2'd1;
        add("JALR", o, rbit(), 1'b0, 1'b1);
        plan_jal();
      end
      OP_LUI, OP_AUIPC: begin
        o = '0; o.immSource = 3'd4; o.srcB = 2'd1; o.srcA = (op == OP_LUI) ? 2'd3 : 2'd1;
        add("LUI", o, rbit(), 1'b0, 1'b1);
        plan_writeback_alu();
      end
      OP_BRANCH: begin
        o = '0; o.srcA = 2'd2; o.alu = 4'd1; o.PCWrite = br_taken(f3, flags);
        add("BRANCH", o, rbit(), 1'b0, 1'b1);
        if (f3 == 3'b010 || f3 == 3'b011) plan_trap();
      end
      default: plan_trap();
    endcase
  endtask

  // ---------------- monitor ----------------
  step_t mon_e;
  outs_t mon_a;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, srcA, srcB, resultSrc,
               immSource, ALUControl, illegal};
      total++;
      if (mon_a === mon_e.exp) passed++;
      else $display("FAIL %0s op=%b f3=%b: actual=%05h required=%05h (t=%0t)",
                    mon_e.tag, mon_e.op, mon_e.f3, mon_a, mon_e.exp, $time);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    step_t       s;
    logic [6:0]  op;
    logic [6:0]  bad_ops [4];
    int          pick;
    bad_ops[0] = 7'b0000000; bad_ops[1] = 7'b1111111;
    bad_ops[2] = 7'b0001111; bad_ops[3] = 7'b1110011;

    cur_op = 7'd0; cur_f3 = 3'd0; cur_f75 = 1'b0; cur_flags = 4'd0;
    add("RESET", '0, 1'b0, 1'b1, 1'b0);
    add("RESET", '0, 1'b0, 1'b1, 1'b0);
    add_rst_state();

    plan_instr(OP_I,      3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);  // addi
    plan_instr(OP_LOAD,   3'b010, 1'b0, 4'b0000, 0, 2, 1'b0);  // lw, 2 wait cycles
    plan_instr(OP_R,      3'b000, 1'b1, 4'b0000, 0, 0, 1'b0);  // sub
    plan_instr(OP_I,      3'b000, 1'b1, 4'b0000, 0, 0, 1'b0);  // addi with bit30
    plan_instr(OP_I,      3'b101, 1'b1, 4'b0000, 1, 0, 1'b0);  // srai
    plan_instr(OP_BRANCH, 3'b000, 1'b0, 4'b0100, 0, 0, 1'b0);  // beq taken
    plan_instr(OP_BRANCH, 3'b100, 1'b0, 4'b1000, 0, 0, 1'b0);  // blt taken
    plan_instr(OP_BRANCH, 3'b111, 1'b0, 4'b0000, 0, 0, 1'b0);  // bgeu not taken
    plan_instr(7'b0000000, 3'b000, 1'b0, 4'b0000, 0, 0, 1'b0); // illegal
    plan_instr(OP_STORE,  3'b010, 1'b0, 4'b0000, 2, 0, 1'b1);  // reset mid-store wait
    plan_instr(OP_JAL,    3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    plan_instr(OP_JALR,   3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    plan_instr(OP_LUI,    3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    plan_instr(OP_AUIPC,  3'b000, 1'b0, 4'b0000, 0, 0, 1'b0);
    plan_instr(OP_BRANCH, 3'b011, 1'b0, 4'b0000, 0, 0, 1'b0);  // reserved branch funct3

    for (int n = 0; n < 200; n++) begin
      pick = int'($urandom_range(0, 11));
      case (pick)
        0:       op = OP_LOAD;
        1:       op = OP_STORE;
        2:       op = OP_R;
        3, 11:   op = OP_I;
        4:       op = OP_JAL;
        5:       op = OP_JALR;
        6:       op = OP_LUI;
        7:       op = OP_AUIPC;
        8, 9:    op = OP_BRANCH;
        default: op = bad_ops[$urandom_range(0, 3)];
      endcase
      plan_instr(op, 3'($urandom_range(0, 7)), rbit(), 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 (op == OP_STORE) && ($urandom_range(0, 7) == 0));
    end

    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      reset    = s.rst;
      memReady = s.rdy;
      OPCode   = s.op;
      funct3   = s.f3;
      funct75  = s.f75;
      ALUFlags = s.flags;
      if (s.chk) sb_q.push_back(s);
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    total++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
